// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-by-word block refill.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module dm_cache_ctrl #(
  parameter int CACHE_LINES     = 32,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_read,
  input  logic        Mem_Write,
  input  logic [31:0] a_data_mem,
  input  logic [31:0] w_data_mem,
  output logic [31:0] r_data_mem,
  output logic        stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic        mem_ack
);

  localparam int IW = $clog2(CACHE_LINES);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int TW = 32 - 2 - OW - IW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t state;
  logic [OW-1:0] cnt;

  logic [CACHE_LINES-1:0] valid_q;
  logic [TW-1:0]          tag_q  [CACHE_LINES];
  logic [31:0]            data_q [CACHE_LINES][WORDS_PER_BLOCK];

  // Core-side address fields select the line for lookups; the registered
  // memory address selects the line being refilled or written through.
  logic [TW-1:0] a_tag, m_tag;
  logic [IW-1:0] a_idx, m_idx;
  logic [OW-1:0] a_word, m_word;

  assign a_tag  = a_data_mem[31 -: TW];
  assign a_idx  = a_data_mem[2+OW +: IW];
  assign a_word = a_data_mem[2 +: OW];
  assign m_tag  = mem_addr[31 -: TW];
  assign m_idx  = mem_addr[2+OW +: IW];
  assign m_word = mem_addr[2 +: OW];

  logic a_hit, m_hit, rd_hit, rd_miss, wr_req, last_word;

  assign a_hit     = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign m_hit     = valid_q[m_idx] && (tag_q[m_idx] == m_tag);
  assign wr_req    = (state == IDLE) && Mem_Write;
  assign rd_hit    = (state == IDLE) && Mem_read && !Mem_Write && a_hit;
  assign rd_miss   = (state == IDLE) && Mem_read && !Mem_Write && !a_hit;
  assign last_word = (cnt == OW'(WORDS_PER_BLOCK - 1));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    stall      = 1'b0;
    r_data_mem = '0;
    case (state)
      IDLE: begin
        stall = wr_req || rd_miss;
        if (rd_hit) r_data_mem = data_q[a_idx][a_word];
      end
      REFILL, WRITE: stall = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_q   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req) begin
            state     <= WRITE;
            mem_wr    <= 1'b1;
            mem_addr  <= a_data_mem & ~32'd3;
            mem_wdata <= w_data_mem;
          end else if (rd_miss) begin
            // Line is invalidated up front so a partial refill never hits.
            state          <= REFILL;
            cnt            <= '0;
            valid_q[a_idx] <= 1'b0;
            mem_rd         <= 1'b1;
            mem_addr       <= {a_data_mem[31:2+OW], {OW{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              valid_q[m_idx] <= 1'b1;
              mem_rd         <= 1'b0;
              state          <= IDLE;
            end else begin
              mem_addr[2 +: OW] <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            state  <= WDONE;
          end
        end
        WDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the reset-cleared valid bits
  // alone decide whether their contents can ever be observed.
  always_ff @(posedge clk) begin
    if (!reset && mem_ack) begin
      if (state == REFILL) begin
        data_q[m_idx][cnt] <= mem_rdata;
        if (last_word) tag_q[m_idx] <= m_tag;
      end else if (state == WRITE && m_hit) begin
        data_q[m_idx][m_word] <= mem_wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // The hit that completes a refilled read belongs to its miss, not to hit_cnt.
  logic refill_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      refill_done_q <= 1'b0;
    end else begin
      refill_done_q <= (state == REFILL) && mem_ack && last_word;
      if (rd_hit && !refill_done_q && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (rd_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a bench-side main memory answers mem_rd/mem_wr
// after a fixed latency; loads, stores, conflicts and reset mid-refill are checked.
module tb_dm_cache_ctrl;

  localparam int WPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_read, Mem_Write;
  logic [31:0] a_data_mem, w_data_mem, r_data_mem;
  logic        stall, mem_rd, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Mem_read   (Mem_read),
    .Mem_Write  (Mem_Write),
    .a_data_mem (a_data_mem),
    .w_data_mem (w_data_mem),
    .r_data_mem (r_data_mem),
    .stall      (stall),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef CACHE_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .mem_ack    (mem_ack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bench main memory: preloaded words, unwritten words read as addr ^ 5A5A_0000.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rd_log [$];
  int rd_acks = 0;
  int wr_acks = 0;
  int both_high = 0;
  int lat = 0;

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Each request is acked on its second cycle; ack lasts exactly one cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      lat     = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_rd || mem_wr) begin
      if (lat == 1) begin
        lat     = 0;
        mem_ack = 1'b1;
        if (mem_rd) begin
          mem_rdata = bmem_rd(mem_addr);
          rd_acks++;
          rd_log.push_back(mem_addr);
        end else begin
          bmem[mem_addr] = mem_wdata;
          wr_acks++;
        end
      end else begin
        lat++;
      end
    end
  end

  always @(negedge clk) if (mem_rd && mem_wr) both_high++;

  task automatic do_read(input string tag, input logic [31:0] addr, input bit miss,
                         input logic [31:0] exp);
    int base_rd, base_wr, n;
    @(negedge clk);
    base_rd = rd_acks;
    base_wr = wr_acks;
    Mem_read = 1'b1; Mem_Write = 1'b0; a_data_mem = addr;
    #1;
    check({tag, "_stall_first"}, stall, 32'(miss));
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_in_budget"}, 32'(n < 200), 32'd1);
    check({tag, "_data"}, r_data_mem, exp);
    check({tag, "_mem_rd_low"}, mem_rd, 32'd0);
    check({tag, "_rd_acks"}, rd_acks - base_rd, miss ? WPB : 0);
    check({tag, "_wr_acks"}, wr_acks - base_wr, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input bit also_read, input logic [31:0] exp_maddr);
    int base_rd, base_wr, n;
    @(negedge clk);
    base_rd = rd_acks;
    base_wr = wr_acks;
    Mem_Write = 1'b1; Mem_read = also_read; a_data_mem = addr; w_data_mem = data;
    #1;
    check({tag, "_stall_first"}, stall, 32'd1);
    @(negedge clk); #1;
    check({tag, "_mem_wr"}, mem_wr, 32'd1);
    check({tag, "_mem_rd"}, mem_rd, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, exp_maddr);
    check({tag, "_mem_wdata"}, mem_wdata, data);
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_in_budget"}, 32'(n < 200), 32'd1);
    check({tag, "_wdone_mem_wr"}, mem_wr, 32'd0);
    check({tag, "_wr_acks"}, wr_acks - base_wr, 32'd1);
    check({tag, "_rd_acks"}, rd_acks - base_rd, 32'd0);
    @(negedge clk);
    Mem_Write = 1'b0; Mem_read = 1'b0;
    #1;
    check({tag, "_idle_stall"}, stall, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    reset = 1'b1; Mem_read = 1'b0; Mem_Write = 1'b0;
    a_data_mem = '0; w_data_mem = '0; mem_ack = 1'b0; mem_rdata = '0;
    bmem[32'h40] = 32'd11; bmem[32'h44] = 32'd22;
    bmem[32'h48] = 32'd33; bmem[32'h4C] = 32'd44;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_stall", stall, 32'd0);
    check("rst_mem_rd", mem_rd, 32'd0);
    check("rst_mem_wr", mem_wr, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_r_data", r_data_mem, 32'd0);
`ifdef CACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // Cold miss refills the block in word order, then a same-block hit.
    do_read("rd40_miss", 32'h0000_0040, 1'b1, 32'd11);
    check("refill_addr0", rd_log[0], 32'h40);
    check("refill_addr1", rd_log[1], 32'h44);
    check("refill_addr2", rd_log[2], 32'h48);
    check("refill_addr3", rd_log[3], 32'h4C);
    do_read("rd48_hit", 32'h0000_0048, 1'b0, 32'd33);

    // Write-through hit updates the cached word.
    do_write("wr44_hit", 32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 32'h0000_0044);
    do_read("rd44_hit", 32'h0000_0044, 1'b0, 32'hDEAD_BEEF);

    // Read and write together: write wins; byte offset bits are dropped.
    do_write("wr4e_prio", 32'h0000_004E, 32'h1234_5678, 1'b1, 32'h0000_004C);
    do_read("rd4c_hit", 32'h0000_004C, 1'b0, 32'h1234_5678);

    // Write miss does not allocate; a later read must refill.
    do_write("wr1000_miss", 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 32'h0000_1000);
    do_read("rd1000_miss", 32'h0000_1000, 1'b1, 32'hCAFE_F00D);

    // Conflicting tag on the same index evicts the 0x40 block.
    do_read("rd240_miss", 32'h0000_0240, 1'b1, 32'h5A5A_0240);
    do_read("rd40_remiss", 32'h0000_0040, 1'b1, 32'd11);
    do_read("rd44_after", 32'h0000_0044, 1'b0, 32'hDEAD_BEEF);

    @(negedge clk);
    Mem_read = 1'b0; Mem_Write = 1'b0;
`ifdef CACHE_STATS_EN
    check("stats_hit_cnt", hit_cnt, 32'd4);
    check("stats_miss_cnt", miss_cnt, 32'd4);
`endif

    // Reset lands on the cycle of the second refill ack.
    @(negedge clk);
    base = rd_acks;
    Mem_read = 1'b1; a_data_mem = 32'h0000_0240;
    n = 0;
    while (!(mem_ack && rd_acks == base + 2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", 32'(n < 200), 32'd1);
    check("rst_mid_stall_before", stall, 32'd1);
`ifdef CACHE_STATS_EN
    check("rst_mid_miss_cnt", miss_cnt, 32'd5);
`endif
    reset = 1'b1; Mem_read = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_mem_rd", mem_rd, 32'd0);
    check("rst_mid_stall", stall, 32'd0);
    reset = 1'b0;
`ifdef CACHE_STATS_EN
    check("rst_mid_hit_cnt0", hit_cnt, 32'd0);
    check("rst_mid_miss_cnt0", miss_cnt, 32'd0);
`endif
    do_read("rd40_post_rst", 32'h0000_0040, 1'b1, 32'd11);
    do_read("rd48_post_rst", 32'h0000_0048, 1'b0, 32'd33);
    @(negedge clk);
    Mem_read = 1'b0;
`ifdef CACHE_STATS_EN
    check("final_hit_cnt", hit_cnt, 32'd1);
    check("final_miss_cnt", miss_cnt, 32'd1);
`endif
    check("rd_wr_never_both", both_high, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
